// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: active-low
// segment codes {g,f,e,d,c,b,a}, the all-off digit enable and the digit index type.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] AN_OFF = 3'b111;

  typedef logic [1:0] dig_t;

  localparam dig_t DIG_ONES     = 2'd0;
  localparam dig_t DIG_TENS     = 2'd1;
  localparam dig_t DIG_HUNDREDS = 2'd2;

  // One-cold digit enable; the unused index 3 keeps every digit dark.
  function automatic logic [2:0] an_onecold(input dig_t d);
    logic [2:0] an;
    an = AN_OFF;
    case (d)
      DIG_ONES:     an = 3'b110;
      DIG_TENS:     an = 3'b101;
      DIG_HUNDREDS: an = 3'b011;
      default:      an = AN_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational BCD nibble to active-low seven-segment code; A-F show a dash.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nib_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Three-digit common-anode scan driver with frame-aligned value update.
// Leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd,
  input  logic        bcd_load,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_done
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  dig_t          dig_q, dig_d;
  logic [11:0]   disp_q, disp_d;
  logic [11:0]   pend_q, pend_d;
  logic          pend_flag_q, pend_flag_d;
  logic          wrap_q;
  logic          tick, swap;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    dec_seg, seg_d;
  logic [2:0]    an_d;
  logic [6:0]    seg_q;
  logic [2:0]    an_q;
  logic          frame_done_q;

  always_comb begin
    tick        = (div_cnt_q == DIV_MAX);
    swap        = tick && (dig_q == DIG_HUNDREDS);
    div_cnt_d   = tick ? '0 : div_cnt_q + DW'(1);
    dig_d       = dig_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    if (tick) begin
      dig_d = swap ? DIG_ONES : dig_q + 2'd1;
    end
    // Swap takes the pre-cycle pending value; a same-cycle load re-arms the flag.
    if (swap && pend_flag_q) begin
      disp_d      = pend_q;
      pend_flag_d = 1'b0;
    end
    if (bcd_load) begin
      pend_d      = bcd;
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    nib = disp_q[3:0];
    case (dig_q)
      DIG_TENS:     nib = disp_q[7:4];
      DIG_HUNDREDS: nib = disp_q[11:8];
      default:      nib = disp_q[3:0];
    endcase
  end

`ifdef BCD_SCAN_LZB_EN
  assign blank = ((dig_q == DIG_HUNDREDS) && (disp_q[11:8] == 4'd0)) ||
                 ((dig_q == DIG_TENS)     && (disp_q[11:4] == 8'd0));
`else
  assign blank = 1'b0;
`endif

  sevenseg_decode u_decode (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  assign seg_d = blank ? SEG_BLANK : dec_seg;
  assign an_d  = an_onecold(dig_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      dig_q        <= DIG_ONES;
      disp_q       <= 12'h000;
      pend_q       <= 12'h000;
      pend_flag_q  <= 1'b0;
      wrap_q       <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      dig_q        <= dig_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      wrap_q       <= swap;
      seg_q        <= seg_d;
      an_q         <= an_d;
      // Delayed one cycle so the pulse lines up with the new frame's digit 0.
      frame_done_q <= wrap_q;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
